// File: rtl/audio_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : audio_timing_gen
//  Description : I2S / left-justified / TDM frame timing generator. Produces
//                BCLK, LRCLK (word select or one-BCLK frame sync), per-bit
//                shift strobes, per-slot load strobes and a frame-rate pulse,
//                with clean start and end-of-frame stop behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_timing_gen #(
  parameter int CLK_RATE      = 24576000,
  parameter int AUDIO_RATE    = 48000,
  parameter int BITS_PER_SLOT = 16,
  parameter int SLOTS         = 2,
  parameter int FORMAT        = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  output logic                     active,
  output logic                     audio_clk,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_data_shift_strobe,
  output logic                     i2s_data_load_strobe,
  output logic [$clog2(SLOTS)-1:0] load_slot
);

  // Half-period of BCLK in clk cycles, rounded to nearest.
  localparam longint DIV      = longint'(AUDIO_RATE) * longint'(SLOTS) *
                                longint'(BITS_PER_SLOT) * 64'sd2;
  localparam longint DIV_SAFE = (DIV > 0) ? DIV : 64'sd1;
  localparam longint H_L      = (longint'(CLK_RATE) + DIV_SAFE / 2) / DIV_SAFE;
  localparam int     H        = (H_L < 1) ? 1 : int'(H_L);
  localparam int     HW       = (H > 1) ? $clog2(H) : 1;
  localparam int     SW       = $clog2(SLOTS);
  localparam int     BW       = $clog2(BITS_PER_SLOT);

  localparam logic [HW-1:0] H_MAX    = HW'(H - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOTS - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(BITS_PER_SLOT - 1);
  // First data bit inside a slot: I2S delays the MSB by one BCLK.
  localparam logic [BW-1:0] D_BIT    = BW'((FORMAT == 0) ? 1 : 0);
  localparam bit            TDM      = (SLOTS > 2);

  generate
    if (BITS_PER_SLOT < 8 || BITS_PER_SLOT > 32 || SLOTS < 2 || SLOTS > 16 ||
        (FORMAT != 0 && FORMAT != 1) || AUDIO_RATE < 1 || H_L < 1) begin : g_param_error
      $error("audio_timing_gen: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q,  hcnt_d;
  logic [SW-1:0]   slot_q,  slot_d;
  logic [BW-1:0]   bit_q,   bit_d;
  logic            bclk_q,  bclk_d;
  logic            lrclk_q, lrclk_d;
  logic            shift_q, shift_d;
  logic            load_q,  load_d;
  logic            aclk_q,  aclk_d;
  logic            active_q, active_d;
  logic [SW-1:0]   lslot_q, lslot_d;

  logic [SW-1:0]   nslot;
  logic [BW-1:0]   nbit;
  logic            fall;
  logic            ev;

  // BCLK is about to go 1->0: this is the next falling-edge event.
  assign fall = bclk_q && (hcnt_q == H_MAX);

  // Frame position that follows the current one, wrapping at frame end.
  always_comb begin
    nbit  = bit_q + BW'(1);
    nslot = slot_q;
    if (bit_q == BIT_MAX) begin
      nbit  = '0;
      nslot = (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);
    end
  end

  // State machine, BCLK divider, frame position and registered strobe decode.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bclk_d  = bclk_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    lrclk_d = lrclk_q;
    lslot_d = lslot_q;
    shift_d = 1'b0;
    load_d  = 1'b0;
    aclk_d  = 1'b0;
    ev      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Start-up cycle counts as a falling-edge event at pos 0 with bclk low.
        if (enable) begin
          state_d = S_RUN;
          hcnt_d  = '0;
          bclk_d  = 1'b0;
          slot_d  = '0;
          bit_d   = '0;
          ev      = 1'b1;
        end
      end
      S_RUN, S_STOP: begin
        state_d = enable ? S_RUN : S_STOP;
        if (hcnt_q == H_MAX) begin
          hcnt_d = '0;
          bclk_d = ~bclk_q;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
        if (fall) begin
          if (!enable && (nbit == '0) && (nslot == '0)) begin
            // Frame complete while stopping: drop to idle silently.
            state_d = S_IDLE;
            hcnt_d  = '0;
            bclk_d  = 1'b0;
            slot_d  = '0;
            bit_d   = '0;
            lrclk_d = 1'b0;
            lslot_d = '0;
          end else begin
            slot_d = nslot;
            bit_d  = nbit;
            ev     = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        hcnt_d  = '0;
        bclk_d  = 1'b0;
        slot_d  = '0;
        bit_d   = '0;
        lrclk_d = 1'b0;
        lslot_d = '0;
      end
    endcase

    if (ev) begin
      shift_d = 1'b1;
      aclk_d  = (slot_d == '0) && (bit_d == '0);
      load_d  = (bit_d == D_BIT);
      if (load_d) begin
        lslot_d = slot_d;
      end
      lrclk_d = TDM ? aclk_d : (slot_d != '0);
    end

    active_d = (state_d != S_IDLE);
  end

  // State and timing registers; reset forces the idle condition immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      slot_q   <= '0;
      bit_q    <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      shift_q  <= 1'b0;
      load_q   <= 1'b0;
      aclk_q   <= 1'b0;
      active_q <= 1'b0;
      lslot_q  <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      slot_q   <= slot_d;
      bit_q    <= bit_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      shift_q  <= shift_d;
      load_q   <= load_d;
      aclk_q   <= aclk_d;
      active_q <= active_d;
      lslot_q  <= lslot_d;
    end
  end

  assign active                = active_q;
  assign audio_clk             = aclk_q;
  assign i2s_bclk              = bclk_q;
  assign i2s_lrclk             = lrclk_q;
  assign i2s_data_shift_strobe = shift_q;
  assign i2s_data_load_strobe  = load_q;
  assign load_slot             = lslot_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_timing_gen
//  Description : Scoreboard bench for audio_timing_gen. Three instances run
//                side by side (I2S default, left-justified, 8-slot TDM), all
//                with a 512-clk frame, sharing enable and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       act[3], ac[3], bk[3], lr[3], sh[3], ld[3];
  logic [0:0] ls0, ls1;
  logic [2:0] ls2;
  logic [3:0] sl[3];

  assign sl[0] = {3'b000, ls0};
  assign sl[1] = {3'b000, ls1};
  assign sl[2] = {1'b0, ls2};

  audio_timing_gen u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .active(act[0]),
    .audio_clk(ac[0]), .i2s_bclk(bk[0]), .i2s_lrclk(lr[0]),
    .i2s_data_shift_strobe(sh[0]), .i2s_data_load_strobe(ld[0]), .load_slot(ls0)
  );

  audio_timing_gen #(.FORMAT(1)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .active(act[1]),
    .audio_clk(ac[1]), .i2s_bclk(bk[1]), .i2s_lrclk(lr[1]),
    .i2s_data_shift_strobe(sh[1]), .i2s_data_load_strobe(ld[1]), .load_slot(ls1)
  );

  audio_timing_gen #(.SLOTS(8), .BITS_PER_SLOT(32), .FORMAT(0)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .active(act[2]),
    .audio_clk(ac[2]), .i2s_bclk(bk[2]), .i2s_lrclk(lr[2]),
    .i2s_data_shift_strobe(sh[2]), .i2s_data_load_strobe(ld[2]), .load_slot(ls2)
  );

  typedef struct {
    int cyc;
    int ac;
    int ld;
    int slot;
    int lr;
  } ev_t;

  ev_t q0[$], q1[$], q2[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit prev_lr[3] = '{default: 1'b0};

  // Hand-derived per-instance constants: half period, slots, bits, data delay.
  function automatic int hh(input int i);   return (i == 2) ? 1  : 8;  endfunction
  function automatic int nsl(input int i);  return (i == 2) ? 8  : 2;  endfunction
  function automatic int bps(input int i);  return (i == 2) ? 32 : 16; endfunction
  function automatic int dd(input int i);   return (i == 1) ? 0  : 1;  endfunction

  function automatic ev_t mk(input int i, input int c0, input int k);
    ev_t e;
    int  f   = nsl(i) * bps(i);
    int  pos = k % f;
    e.cyc  = c0 + 1 + 2 * hh(i) * k;
    e.ac   = (pos == 0) ? 1 : 0;
    e.ld   = ((pos % bps(i)) == dd(i)) ? 1 : 0;
    e.slot = pos / bps(i);
    if (nsl(i) == 2) e.lr = (pos >= bps(i)) ? 1 : 0;
    else             e.lr = (pos == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic qpush(input int i, input ev_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpop(input int i, output ev_t e);
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Expected events for whole frames starting at the enabling edge after c0.
  task automatic push_frames(input int c0, input int nfr);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < nfr * nsl(i) * bps(i); k++) qpush(i, mk(i, c0, k));
    end
  endtask

  // Expected events whose cycle is at or before cmax.
  task automatic push_upto(input int c0, input int cmax);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; c0 + 1 + 2 * hh(i) * k <= cmax; k++) qpush(i, mk(i, c0, k));
    end
  endtask

  task automatic chk(input string name, input int i, input int a, input int r);
    n_checks++;
    if (a != r) begin
      n_fail++;
      $display("FAIL %s (dut%0d) at cycle %0d: got %0d, expected %0d", name, i, cyc, a, r);
    end
  endtask

  task automatic flag(input string name, input int i, input int a, input int r);
    n_checks++;
    n_fail++;
    $display("FAIL %s (dut%0d) at cycle %0d: got %0d, expected %0d", name, i, cyc, a, r);
  endtask

  function automatic int outs(input int i);
    return int'({act[i], ac[i], bk[i], lr[i], sh[i], ld[i], sl[i]});
  endfunction

  task automatic check_idle(input string name);
    for (int i = 0; i < 3; i++) chk(name, i, outs(i), 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: consumes one expected record per shift strobe on each instance.
  task automatic mon(input int i);
    ev_t e;
    if ((ac[i] || ld[i]) && !sh[i]) flag("strobe_without_shift", i, int'({ac[i], ld[i]}), 0);
    if (act[i] && !sh[i] && (lr[i] != prev_lr[i])) flag("lrclk_off_event", i, int'(lr[i]), int'(prev_lr[i]));
    prev_lr[i] = lr[i];
    if (sh[i]) begin
      if (qsize(i) == 0) begin
        flag("unexpected_event", i, 1, 0);
      end else begin
        qpop(i, e);
        chk("event_cycle", i, cyc, e.cyc);
        chk("audio_clk", i, int'(ac[i]), e.ac);
        chk("load_strobe", i, int'(ld[i]), e.ld);
        if (e.ld != 0) chk("load_slot", i, int'(sl[i]), e.slot);
        chk("lrclk", i, int'(lr[i]), e.lr);
        chk("bclk_at_event", i, int'(bk[i]), 0);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  int c0;
  int x;

  initial begin
    reset_n = 1'b1;
    enable  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("idle_after_release");

    // Three frames; enable dropped at pos 5 of the third frame.
    c0 = cyc;
    push_frames(c0, 3);
    enable = 1'b1;
    wait_until(c0 + 1 + 7);
    chk("bclk_low_half", 0, int'(bk[0]), 0);
    chk("tdm_bclk_odd", 2, int'(bk[2]), 1);
    wait_until(c0 + 1 + 8);
    chk("bclk_high_half", 0, int'(bk[0]), 1);
    chk("tdm_bclk_even", 2, int'(bk[2]), 0);
    wait_until(c0 + 1 + 15);
    chk("bclk_high_end", 0, int'(bk[0]), 1);
    wait_until(c0 + 1 + 16 * 69 + 3);
    enable = 1'b0;
    wait_until(c0 + 1 + 1535);
    for (int i = 0; i < 3; i++) chk("active_in_stop", i, int'(act[i]), 1);
    wait_until(c0 + 1 + 1536);
    check_idle("stop_to_idle");

    // Enable pulsed low for 3 clk mid-frame, then final stop in frame 1.
    repeat (4) @(negedge clk);
    c0 = cyc;
    push_frames(c0, 2);
    enable = 1'b1;
    wait_until(c0 + 200);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_until(c0 + 700);
    enable = 1'b0;
    wait_until(c0 + 1024);
    chk("active_before_end", 0, int'(act[0]), 1);
    wait_until(c0 + 1025);
    check_idle("pulse_stop_idle");

    // Asynchronous reset mid-frame with BCLK high.
    repeat (4) @(negedge clk);
    c0 = cyc;
    x  = c0 + 1 + 16 * 20 + 10;
    push_upto(c0, x);
    enable = 1'b1;
    wait_until(x);
    chk("bclk_high_pre_reset", 0, int'(bk[0]), 1);
    #2 reset_n = 1'b0;
    enable = 1'b0;
    #1 check_idle("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("idle_after_reset");

    // Restart from pos 0 after reset, one frame.
    c0 = cyc;
    push_frames(c0, 1);
    enable = 1'b1;
    wait_until(c0 + 20);
    enable = 1'b0;
    wait_until(c0 + 513);
    check_idle("restart_stop_idle");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("queue_drained", i, qsize(i), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_timing_gen.md
AUDIO_TIMING_GEN -- requirements
Module: audio_timing_gen

Interface
REQ-001 The block SHALL have parameter CLK_RATE, default 24576000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter AUDIO_RATE, default 48000, meaning frame (sample) rate in Hz.
REQ-003 The block SHALL have parameter BITS_PER_SLOT, default 16, meaning BCLK periods per slot; legal range 8..32.
REQ-004 The block SHALL have parameter SLOTS, default 2, meaning slots per frame; legal range 2..16; 2 = stereo I2S/LJ, >2 = TDM.
REQ-005 The block SHALL have parameter FORMAT, default 0, meaning 0 = I2S (MSB delayed one BCLK, D=1) and 1 = left-justified (D=0).
REQ-006 The block SHALL have the following ports, with one clock and an asynchronous active-low reset:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run request
- active  out  1  timing running (RUN or STOP state)
- audio_clk  out  1  one-clk pulse at each frame start
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select / frame sync
- i2s_data_shift_strobe  out  1  one-clk pulse at each BCLK falling edge
- i2s_data_load_strobe  out  1  one-clk pulse at the first data bit of each slot
- load_slot  out  clog2(SLOTS)  slot index valid with load strobe

Function
REQ-007 H SHALL equal round(CLK_RATE / (AUDIO_RATE*SLOTS*BITS_PER_SLOT*2)), computed by integer add-half division; H<1 or an out-of-range parameter SHALL be an elaboration error.
REQ-008 The state machine SHALL have states IDLE, RUN and STOP:
- IDLE->RUN when enable=1.
- RUN->STOP when enable=0.
- STOP->RUN when enable=1.
- STOP->IDLE at the falling-edge event that would begin pos 0.
REQ-009 In IDLE, all counters SHALL be 0; bclk, lrclk, all strobes and active SHALL be 0; load_slot SHALL hold 0.
REQ-010 In RUN/STOP, a half-period counter SHALL count 0..H-1, and i2s_bclk SHALL toggle when it reaches H-1, giving a BCLK period of 2H clk.
REQ-011 A "falling-edge event" SHALL be the clk cycle in which the registered i2s_bclk goes 1->0.
- The first RUN cycle after IDLE SHALL also count as a falling-edge event, with bclk=0.
REQ-012 Frame position pos (0..SLOTS*BITS_PER_SLOT-1) SHALL be held as slot and bit counters with no divider.
- pos SHALL advance on each falling-edge event and wrap to 0.
- pos SHALL be 0 on the first RUN event.
REQ-013 i2s_data_shift_strobe SHALL be 1 exactly in falling-edge-event cycles.
REQ-014 audio_clk SHALL be 1 exactly in falling-edge-event cycles that begin pos 0.
REQ-015 i2s_data_load_strobe SHALL be 1 in the falling-edge event beginning pos = s*BITS_PER_SLOT + D (mod frame), for each slot s.
- load_slot SHALL equal s in that cycle.
- The load strobe coincides with the shift strobe; load takes precedence.
REQ-016 For SLOTS=2, i2s_lrclk SHALL be 0 for pos 0..BITS_PER_SLOT-1 and 1 for the remaining positions.
REQ-017 For SLOTS>2, i2s_lrclk SHALL be 1 only during pos 0, giving a one-BCLK-wide pulse.
REQ-018 i2s_lrclk SHALL change in the same clk cycle as the falling-edge event.
REQ-019 All outputs SHALL be registered, with no combinational path from enable to any output.
REQ-020 In STOP, timing SHALL continue unchanged through the end of the current frame.
- On the terminating event, no strobes SHALL fire and state SHALL become IDLE.
- Re-enable during STOP SHALL continue without a glitch or pos discontinuity.
REQ-021 enable toggled within one frame (1->0->1) SHALL NOT disturb BCLK, LRCLK or pos.

Reset
REQ-022 reset_n=0 SHALL asynchronously force state IDLE, all counters to 0 and every output to 0.
- This SHALL hold regardless of the current state, including mid-frame.
REQ-023 After reset_n deasserts, the block SHALL stay in IDLE until enable=1 is sampled on a clk edge.

Verification
REQ-024 Defaults, enable=1: expect H=8, BCLK period 16 clk, audio_clk every 512 clk, lrclk low for 16 BCLK then high for 16 BCLK, load strobes at pos 1 (slot 0) and pos 17 (slot 1).
REQ-025 FORMAT=1 with defaults: expect load strobes at pos 0 and pos 16, with the load strobe coincident with audio_clk on pos 0.
REQ-026 SLOTS=8, BITS_PER_SLOT=32, FORMAT=0: expect H=1, BCLK period 2 clk, frame 512 clk, lrclk high for exactly 2 clk at pos 0, 8 load strobes per frame with load_slot 0..7 at pos 1, 33, ..., 225.
REQ-027 Defaults, enable dropped at pos 5: expect strobes to continue through pos 31, then IDLE with all outputs 0 and active=0, and no audio_clk pulse at the frame boundary.
REQ-028 Defaults, enable pulsed low for 3 clk mid-frame: expect no change in BCLK/LRCLK period, pos sequence or strobe timing.
REQ-029 reset_n asserted asynchronously mid-frame while BCLK is high: expect all outputs 0 within the same cycle, and restart from pos 0 on the first enabled edge after release.
